// File: rtl/fir_coef_loader_if.sv
// Control-side coefficient write bus for fir_coef_loader.
// The control path is the master; the loader is the slave and answers with wr_ready.
interface fir_coef_loader_if #(
    parameter int CW = 16
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [2:0]           wr_addr;
    logic signed [CW-1:0] wr_data;
    logic                 commit;
    logic                 abort;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output commit,
        output abort,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  commit,
        input  abort,
        output wr_ready
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Shadow/active coefficient bank for the symmetric 16-tap FIR; swaps all taps atomically on sample_en.
// Optional macro COEF_PRESET_EN adds preset_sel/preset_load to arm a ROM coefficient set.
module fir_coef_loader #(
    parameter int CW    = 16,
    parameter int VER_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    fir_coef_loader_if.slave     wr,
    input  logic                 sample_en,
`ifdef COEF_PRESET_EN
    input  logic [1:0]           preset_sel,
    input  logic                 preset_load,
`endif
    output logic                 armed,
    output logic                 swap_pulse,
    output logic [VER_W-1:0]     version,
    output logic signed [CW-1:0] coef_0,
    output logic signed [CW-1:0] coef_1,
    output logic signed [CW-1:0] coef_2,
    output logic signed [CW-1:0] coef_3,
    output logic signed [CW-1:0] coef_4,
    output logic signed [CW-1:0] coef_5,
    output logic signed [CW-1:0] coef_6,
    output logic signed [CW-1:0] coef_7
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t           state_reg;
    logic [7:0]       wm_reg;
    logic             armed_reg;
    logic             swap_pulse_reg;
    logic [VER_W-1:0] version_reg;

    logic do_abort;
    logic do_write;
    logic do_swap;
    logic do_preset;
    logic commit_ok;

    // 4 kHz lowpass set, shared by reset and preset 0
    function automatic logic signed [CW-1:0] rst_coef(input int idx);
        logic signed [CW-1:0] v;
        case (idx)
            0:       v = CW'(-9);
            1:       v = CW'(-5);
            2:       v = CW'(22);
            3:       v = CW'(79);
            4:       v = CW'(164);
            5:       v = CW'(262);
            6:       v = CW'(350);
            default: v = CW'(402);
        endcase
        return v;
    endfunction

`ifdef COEF_PRESET_EN
    function automatic logic signed [CW-1:0] preset_coef(input logic [1:0] sel, input int idx);
        logic signed [CW-1:0] v;
        v = '0;
        case (sel)
            2'd0: v = rst_coef(idx);
            2'd1: begin
                case (idx)
                    0:       v = CW'(-48);
                    1:       v = CW'(66);
                    2:       v = CW'(-89);
                    3:       v = CW'(121);
                    4:       v = CW'(-167);
                    5:       v = CW'(247);
                    6:       v = CW'(-426);
                    default: v = CW'(1301);
                endcase
            end
            2'd2:    v = (idx == 7) ? CW'(256) : '0;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign wr.wr_ready = (state_reg != ARMED) && !preset_load;
    assign do_preset   = preset_load && (state_reg != ARMED) && !do_abort;
`else
    assign wr.wr_ready = (state_reg != ARMED);
    assign do_preset   = 1'b0;
`endif

    // abort only acts once something is pending, and then overrides everything else
    assign do_abort  = wr.abort && (state_reg != IDLE);
    assign do_write  = wr.wr_valid && wr.wr_ready && !do_abort;
    assign do_swap   = (state_reg == ARMED) && sample_en && !do_abort;
    assign commit_ok = wr.commit && (do_write || (wm_reg != 8'h00));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            wm_reg         <= 8'h00;
            armed_reg      <= 1'b0;
            swap_pulse_reg <= 1'b0;
            version_reg    <= '0;
        end else begin
            swap_pulse_reg <= do_swap;
            if (do_abort) begin
                state_reg <= IDLE;
                wm_reg    <= 8'h00;
                armed_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, LOAD: begin
                        if (do_preset) begin
                            wm_reg    <= 8'hFF;
                            state_reg <= ARMED;
                            armed_reg <= 1'b1;
                        end else begin
                            if (do_write) begin
                                wm_reg[wr.wr_addr] <= 1'b1;
                            end
                            if (commit_ok) begin
                                state_reg <= ARMED;
                                armed_reg <= 1'b1;
                            end else if (do_write) begin
                                state_reg <= LOAD;
                            end
                        end
                    end
                    ARMED: begin
                        if (do_swap) begin
                            wm_reg      <= 8'h00;
                            version_reg <= version_reg + VER_W'(1);
                            state_reg   <= IDLE;
                            armed_reg   <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        armed_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // One shadow/active register pair per tap; every act update happens on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : tap
            logic signed [CW-1:0] sh_reg;
            logic signed [CW-1:0] act_reg;
            logic                 wr_hit;

            assign wr_hit = do_write && (wr.wr_addr == 3'(gi));

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sh_reg  <= rst_coef(gi);
                    act_reg <= rst_coef(gi);
                end else begin
                    if (do_abort) begin
                        sh_reg <= act_reg;
`ifdef COEF_PRESET_EN
                    end else if (do_preset) begin
                        sh_reg <= preset_coef(preset_sel, gi);
`endif
                    end else if (wr_hit) begin
                        sh_reg <= wr.wr_data;
                    end
                    if (do_swap) begin
                        act_reg <= sh_reg;
                    end
                end
            end
        end
    endgenerate

    assign coef_0     = tap[0].act_reg;
    assign coef_1     = tap[1].act_reg;
    assign coef_2     = tap[2].act_reg;
    assign coef_3     = tap[3].act_reg;
    assign coef_4     = tap[4].act_reg;
    assign coef_5     = tap[5].act_reg;
    assign coef_6     = tap[6].act_reg;
    assign coef_7     = tap[7].act_reg;
    assign armed      = armed_reg;
    assign swap_pulse = swap_pulse_reg;
    assign version    = version_reg;

endmodule
